data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe_pkg.sv | 36 +++
 rtl/data_mem_pipe_if.sv | 24 ++
 rtl/data_mem_pipe_load_fmt.sv | 25 ++
 rtl/data_mem_pipe.sv | 114 +++++++++++
 tb/tb_data_mem_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pipe_pkg.sv
// Shared definitions for the pipelined data memory: RISC-V funct3 access codes,
// FSM state type, latency bounds and small access-size helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // Number of bytes touched by an access; the low two funct3 bits encode the size.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bus between a load/store unit (master) and the data memory (slave).
interface data_mem_pipe_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_pipe_load_fmt.sv
// Combinational load formatter: turns four little-endian raw bytes into the
// sign/zero-extended load result and flags funct3 codes that are not loads.
module mem_load_fmt
    import mem_pkg::*;
(
    input  logic [3:0][7:0] raw,
    input  logic [2:0]      funct3,
    output logic [31:0]     value,
    output logic            illegal
);

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (funct3)
            F3_B:    value = {{24{raw[0][7]}}, raw[0]};
            F3_H:    value = {{16{raw[1][7]}}, raw[1], raw[0]};
            F3_W:    value = raw;
            F3_BU:   value = {24'b0, raw[0]};
            F3_HU:   value = {16'b0, raw[1], raw[0]};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with a fixed-latency, single-outstanding request pipe.
// Stores commit on acceptance; loads are captured on acceptance and returned LAT cycles later.
module data_mem_pipe
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int LAT       = 1,
    parameter int ALIGN_CHK = 1
) (
    input logic             clk,
    input logic             rst,
    data_mem_pipe_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT_EFF = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
    localparam logic [1:0] CNT_INIT = 2'(LAT_EFF - 1);

    logic [7:0]        mem [DEPTH];
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] byte_addr [4];
    logic [3:0][7:0]   raw;
    logic [31:0]       fmt_value;
    logic              fmt_illegal;
    logic              illegal;
    logic              misaligned;
    logic              req_err;
    logic              accept;
    logic              do_write;
    logic [2:0]        nbytes;

    // Byte lanes wrap around the top of the address space.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = bus.req_addr + ADDR_W'(k);
            raw[k]       = mem[byte_addr[k]];
        end
    end

    mem_load_fmt u_fmt (
        .raw     (raw),
        .funct3  (bus.req_funct3),
        .value   (fmt_value),
        .illegal (fmt_illegal)
    );

    always_comb begin
        illegal    = bus.req_we ? !(bus.req_funct3 inside {F3_B, F3_H, F3_W}) : fmt_illegal;
        misaligned = (ALIGN_CHK != 0) && is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
        req_err    = illegal || misaligned;
        nbytes     = access_bytes(bus.req_funct3);
        accept     = bus.req_valid && (state_q == IDLE) && !rst;
        do_write   = accept && bus.req_we && !req_err;
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes) begin
                    mem[byte_addr[k]] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    err_d   = req_err;
                    data_d  = (bus.req_we || req_err) ? 32'd0 : fmt_value;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == WAIT) && (cnt_q == 2'd0);
    assign bus.resp_err   = bus.resp_valid && err_q;
    assign bus.resp_rdata = bus.resp_valid ? data_q : 32'd0;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: three instances (LAT1/aligned, LAT3/aligned, LAT4/unaligned)
// driven by a directed vector table, hand-timed sequences and random traffic against a byte model.
module tb_data_mem_pipe;

    typedef struct {
        int          g;
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst        [3];
    logic        req_valid  [3];
    logic        req_we     [3];
    logic [2:0]  req_funct3 [3];
    logic [7:0]  req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        req_ready  [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    logic [7:0]  mdl [3][256];
    vec_t        vecs [$];
    int          n_cmp;
    int          n_fail;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_pipe_if #(.ADDR_W(8)) bus ();

        assign bus.req_valid  = req_valid[g];
        assign bus.req_we     = req_we[g];
        assign bus.req_funct3 = req_funct3[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;

        data_mem_pipe #(
            .ADDR_W    (8),
            .LAT       ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .ALIGN_CHK ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic bit align_of(input int g);
        return g != 2;
    endfunction

    // Behavioural model: plain byte array, modular addressing, arithmetic extension.
    function automatic void model_op(input int g, input logic we, input logic [2:0] f3,
                                     input int addr, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rdata);
        int          size;
        logic        legal;
        logic [31:0] val;
        size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || (align_of(g) && ((addr % size) != 0));
        rdata = 32'd0;
        if (err) return;
        if (we) begin
            for (int k = 0; k < size; k++) mdl[g][(addr + k) % 256] = wdata[8*k +: 8];
        end else begin
            val = 32'd0;
            for (int k = 0; k < size; k++) val = val | (32'(mdl[g][(addr + k) % 256]) << (8 * k));
            if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            rdata = val;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request, checks handshake timing, and returns the response payload.
    task automatic applyStimulus(input int g, input logic we, input logic [2:0] f3,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input string tag,
                                 output logic got_err, output logic [31:0] got_rdata);
        int n;
        int first_c;
        int pulses;
        @(negedge clk);
        req_we[g]     = we;
        req_funct3[g] = f3;
        req_addr[g]   = addr;
        req_wdata[g]  = wdata;
        req_valid[g]  = 1'b1;
        n = 0;
        while (!req_ready[g] && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready_idle"}, 32'(req_ready[g]), 32'd1);
        got_err   = 1'b0;
        got_rdata = 32'd0;
        first_c   = 0;
        pulses    = 0;
        for (int c = 1; c <= lat_of(g) + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[g] = 1'b0;
            if (c <= lat_of(g)) checkOutput({tag, "_ready_busy"}, 32'(req_ready[g]), 32'd0);
            else                checkOutput({tag, "_ready_back"}, 32'(req_ready[g]), 32'd1);
            if (resp_valid[g]) begin
                pulses++;
                if (first_c == 0) begin
                    first_c   = c;
                    got_err   = resp_err[g];
                    got_rdata = resp_rdata[g];
                end
            end
        end
        checkOutput({tag, "_latency"}, 32'(first_c), 32'(lat_of(g)));
        checkOutput({tag, "_pulses"}, 32'(pulses), 32'd1);
    endtask

    function automatic void add_vec(input int g, input logic we, input logic [2:0] f3,
                                    input logic [7:0] addr, input logic [31:0] wdata,
                                    input logic ee, input logic [31:0] er, input string nm);
        vec_t v;
        v.g = g; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_err = ee; v.exp_rdata = er; v.name = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        ge, me;
        logic [31:0] gr, mr;
        logic [2:0]  f3_pool [10];
        logic [2:0]  f3;
        int          g;

        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_funct3[i] = 3'd0; req_addr[i] = 8'd0; req_wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_ready%0d", i), 32'(req_ready[i]), 32'd1);
            checkOutput($sformatf("reset_valid%0d", i), 32'(resp_valid[i]), 32'd0);
            checkOutput($sformatf("reset_err%0d", i), 32'(resp_err[i]), 32'd0);
            checkOutput($sformatf("reset_rdata%0d", i), resp_rdata[i], 32'd0);
        end

        // Give every byte a known value so random loads are predictable.
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 256; a += 4) begin
                gr = $urandom;
                model_op(i, 1'b1, 3'd2, a, gr, me, mr);
                applyStimulus(i, 1'b1, 3'd2, 8'(a), gr, "init", ge, mr);
                checkOutput("init_err", 32'(ge), 32'd0);
            end
        end

        add_vec(0, 1, 3'b010, 8'h10, 32'h8081_82FF, 0, 32'h0000_0000, "sw_10");
        add_vec(0, 0, 3'b010, 8'h10, 32'h0,         0, 32'h8081_82FF, "lw_10");
        add_vec(0, 0, 3'b000, 8'h10, 32'h0,         0, 32'hFFFF_FFFF, "lb_10");
        add_vec(0, 0, 3'b100, 8'h10, 32'h0,         0, 32'h0000_00FF, "lbu_10");
        add_vec(0, 0, 3'b101, 8'h12, 32'h0,         0, 32'h0000_8081, "lhu_12");
        add_vec(0, 0, 3'b001, 8'h12, 32'h0,         0, 32'hFFFF_8081, "lh_12");
        add_vec(0, 0, 3'b001, 8'h11, 32'h0,         1, 32'h0000_0000, "lh_mis");
        add_vec(0, 0, 3'b010, 8'h12, 32'h0,         1, 32'h0000_0000, "lw_mis");
        add_vec(0, 1, 3'b010, 8'h04, 32'hA1A2_A3A4, 0, 32'h0000_0000, "sw_04");
        add_vec(0, 1, 3'b010, 8'h08, 32'hB1B2_B3B4, 0, 32'h0000_0000, "sw_08");
        add_vec(0, 1, 3'b010, 8'h06, 32'hDEAD_BEEF, 1, 32'h0000_0000, "sw_06_mis");
        add_vec(0, 0, 3'b010, 8'h04, 32'h0,         0, 32'hA1A2_A3A4, "lw_04_kept");
        add_vec(0, 0, 3'b010, 8'h08, 32'h0,         0, 32'hB1B2_B3B4, "lw_08_kept");
        add_vec(0, 1, 3'b010, 8'h20, 32'hFFFF_FFFF, 0, 32'h0000_0000, "sw_20");
        add_vec(0, 1, 3'b001, 8'h20, 32'h1234_ABCD, 0, 32'h0000_0000, "sh_20");
        add_vec(0, 1, 3'b000, 8'h22, 32'h0000_0055, 0, 32'h0000_0000, "sb_22");
        add_vec(0, 0, 3'b010, 8'h20, 32'h0,         0, 32'hFF55_ABCD, "lw_20");
        add_vec(0, 1, 3'b011, 8'h20, 32'h0,         1, 32'h0000_0000, "st_f3_3");
        add_vec(0, 1, 3'b001, 8'h21, 32'h0,         1, 32'h0000_0000, "sh_mis");
        add_vec(0, 0, 3'b010, 8'h20, 32'h0,         0, 32'hFF55_ABCD, "lw_20_kept");
        add_vec(0, 0, 3'b000, 8'h21, 32'h0,         0, 32'hFFFF_FFAB, "lb_21");
        add_vec(0, 0, 3'b001, 8'h22, 32'h0,         0, 32'hFFFF_FF55, "lh_22");
        add_vec(0, 0, 3'b110, 8'h20, 32'h0,         1, 32'h0000_0000, "ld_f3_6");
        add_vec(1, 1, 3'b010, 8'h40, 32'hCAFE_F00D, 0, 32'h0000_0000, "sw_40");
        add_vec(1, 0, 3'b010, 8'h40, 32'h0,         0, 32'hCAFE_F00D, "lw_40_lat3");
        add_vec(1, 0, 3'b000, 8'h43, 32'h0,         0, 32'hFFFF_FFCA, "lb_43");
        add_vec(1, 0, 3'b101, 8'h42, 32'h0,         0, 32'h0000_CAFE, "lhu_42");
        add_vec(1, 0, 3'b001, 8'h40, 32'h0,         0, 32'hFFFF_F00D, "lh_40");
        add_vec(1, 0, 3'b111, 8'h40, 32'h0,         1, 32'h0000_0000, "ld_f3_7");
        add_vec(2, 1, 3'b010, 8'hFE, 32'h1122_3344, 0, 32'h0000_0000, "sw_fe_wrap");
        add_vec(2, 0, 3'b010, 8'hFE, 32'h0,         0, 32'h1122_3344, "lw_fe_wrap");
        add_vec(2, 0, 3'b100, 8'h00, 32'h0,         0, 32'h0000_0022, "lbu_00");
        add_vec(2, 0, 3'b100, 8'h01, 32'h0,         0, 32'h0000_0011, "lbu_01");
        add_vec(2, 0, 3'b001, 8'hFF, 32'h0,         0, 32'h0000_2233, "lh_ff");
        add_vec(2, 1, 3'b100, 8'h10, 32'h0,         1, 32'h0000_0000, "st_f3_4");

        foreach (vecs[i]) begin
            model_op(vecs[i].g, vecs[i].we, vecs[i].f3, int'(vecs[i].addr), vecs[i].wdata, me, mr);
            applyStimulus(vecs[i].g, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].name, ge, gr);
            checkOutput({vecs[i].name, "_err"}, 32'(ge), 32'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_rdata"}, gr, vecs[i].exp_rdata);
        end

        // Reset two cycles into a LAT=4 store: response is dropped, the byte stays.
        @(negedge clk);
        req_we[2] = 1'b1; req_funct3[2] = 3'b000; req_addr[2] = 8'h30; req_wdata[2] = 32'h0000_005A;
        req_valid[2] = 1'b1;
        checkOutput("rst_pre_ready", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        checkOutput("rst_busy_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        checkOutput("rst_after_ready", 32'(req_ready[2]), 32'd1);
        checkOutput("rst_after_valid", 32'(resp_valid[2]), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("rst_no_resp", 32'(resp_valid[2]), 32'd0);
        end
        model_op(2, 1'b1, 3'b000, 'h30, 32'h0000_005A, me, mr);
        applyStimulus(2, 1'b0, 3'b100, 8'h30, 32'd0, "rst_lbu_30", ge, gr);
        checkOutput("rst_lbu_30_rdata", gr, 32'h0000_005A);

        // A request presented together with reset is never accepted.
        @(negedge clk);
        rst[2] = 1'b1;
        req_we[2] = 1'b1; req_funct3[2] = 3'b010; req_addr[2] = 8'h34; req_wdata[2] = 32'hEEEE_EEEE;
        req_valid[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        req_valid[2] = 1'b0;
        checkOutput("rstreq_ready", 32'(req_ready[2]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("rstreq_no_resp", 32'(resp_valid[2]), 32'd0);
            @(negedge clk);
        end
        model_op(2, 1'b0, 3'b010, 'h34, 32'd0, me, mr);
        applyStimulus(2, 1'b0, 3'b010, 8'h34, 32'd0, "rstreq_lw_34", ge, gr);
        checkOutput("rstreq_lw_34_rdata", gr, mr);

        // Illegal load followed by a held request on the LAT=3 instance.
        @(negedge clk);
        req_we[1] = 1'b0; req_funct3[1] = 3'b011; req_addr[1] = 8'h40; req_valid[1] = 1'b1;
        checkOutput("b2b_ready0", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        req_funct3[1] = 3'b010;
        checkOutput("b2b_busy1", 32'(req_ready[1]), 32'd0);
        checkOutput("b2b_noresp1", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_noresp2", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_resp_valid", 32'(resp_valid[1]), 32'd1);
        checkOutput("b2b_resp_err", 32'(resp_err[1]), 32'd1);
        checkOutput("b2b_resp_rdata", resp_rdata[1], 32'd0);
        checkOutput("b2b_resp_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_ready_again", 32'(req_ready[1]), 32'd1);
        checkOutput("b2b_gap_valid", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("b2b_accepted", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_noresp6", 32'(resp_valid[1]), 32'd0);
        @(negedge clk);
        checkOutput("b2b_lw_valid", 32'(resp_valid[1]), 32'd1);
        checkOutput("b2b_lw_err", 32'(resp_err[1]), 32'd0);
        checkOutput("b2b_lw_rdata", resp_rdata[1], 32'hCAFE_F00D);

        // Random traffic against the byte model.
        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        for (int i = 0; i < 150; i++) begin
            logic        we;
            logic [7:0]  addr;
            logic [31:0] wd;
            g    = $urandom_range(0, 2);
            we   = 1'($urandom_range(0, 1));
            f3   = f3_pool[$urandom_range(0, 9)];
            addr = 8'($urandom_range(0, 255));
            wd   = $urandom;
            model_op(g, we, f3, int'(addr), wd, me, mr);
            applyStimulus(g, we, f3, addr, wd, $sformatf("rand%0d", i), ge, gr);
            checkOutput($sformatf("rand%0d_err", i), 32'(ge), 32'(me));
            checkOutput($sformatf("rand%0d_rdata", i), gr, mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
